// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive path.
// Used by the unstuff/shift stage and its interface.
package usb_rx_pkg;

  typedef enum logic {
    SHIFT,
    STUFF
  } unstuff_state_t;

  localparam int USB_DATA_BITS = 8;
  localparam int USB_STUFF_RUN = 6;

endpackage

// File: rtl/rx_unstuff_shift_if.sv
// Bit-stream in / byte-out bundle of the unstuff stage.
// master drives decoded bits, slave returns assembled words.
import usb_rx_pkg::*;

interface rx_unstuff_shift_if #(
  parameter int DATA_BITS = USB_DATA_BITS
);

  logic                 d_orig;
  logic                 shift_enable;
  logic                 eop;
  logic [DATA_BITS-1:0] rx_data;
  logic                 byte_received;
  logic                 stuff_err;

  modport master (
    output d_orig,
    output shift_enable,
    output eop,
    input  rx_data,
    input  byte_received,
    input  stuff_err
  );

  modport slave (
    input  d_orig,
    input  shift_enable,
    input  eop,
    output rx_data,
    output byte_received,
    output stuff_err
  );

endinterface

// File: rtl/flex_counter.sv
// Wrapping counter 0..rollover_val-1 with a registered
// one-cycle flag on the enable that wraps it.
module flex_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag
);

  localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

  logic [NUM_BITS-1:0] count_next;
  logic                flag_next;

  always_comb begin
    count_next = count_out;
    flag_next  = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val - ONE) begin
        count_next = '0;
        flag_next  = 1'b1;
      end else begin
        count_next = count_out + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= count_next;
      rollover_flag <= flag_next;
    end
  end

endmodule

// File: rtl/rx_unstuff_shift.sv
// USB receive unstuffer: drops the stuffed 0 after a run of
// ones and assembles remaining bits LSB-first into words.
module rx_unstuff_shift
  import usb_rx_pkg::*;
#(
  parameter int DATA_BITS = USB_DATA_BITS,
  parameter int STUFF_RUN = USB_STUFF_RUN
) (
  input logic              clk,
  input logic              rst,
  rx_unstuff_shift_if.slave bus
);

  localparam int CW = $clog2(DATA_BITS) + 1;
  localparam int OW = $clog2(STUFF_RUN + 1);
  localparam logic [CW-1:0] ROLL = CW'(DATA_BITS);
  localparam logic [OW-1:0] RUN  = OW'(STUFF_RUN);
  localparam logic [OW-1:0] ONE  = OW'(1);

  unstuff_state_t       state, state_next;
  logic [OW-1:0]        ones_cnt, ones_next;
  logic [DATA_BITS-1:0] data_q;
  logic [CW-1:0]        bit_cnt;
  logic                 shift_acc;
  logic                 err_next;
  logic                 err_q;
  logic                 byte_pulse;

  always_comb begin
    state_next = state;
    ones_next  = ones_cnt;
    shift_acc  = 1'b0;
    err_next   = 1'b0;
    if (bus.eop) begin
      state_next = SHIFT;
      ones_next  = '0;
    end else if (bus.shift_enable) begin
      unique case (1'b1)
        (state == SHIFT): begin
          shift_acc = 1'b1;
          ones_next = bus.d_orig ? ones_cnt + ONE : '0;
          if (ones_next == RUN) state_next = STUFF;
        end
        (state == STUFF): begin
          ones_next  = '0;
          state_next = SHIFT;
          err_next   = bus.d_orig;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SHIFT;
      ones_cnt <= '0;
      data_q   <= '1;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      ones_cnt <= ones_next;
      err_q    <= err_next;
      if (shift_acc) begin
        data_q <= {bus.d_orig, data_q[DATA_BITS-1:1]};
      end
    end
  end

  // eop clears the partial word count; the wrap flag is the byte strobe
  flex_counter #(
    .NUM_BITS (CW)
  ) u_bit_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear         (bus.eop),
    .count_enable  (shift_acc),
    .rollover_val  (ROLL),
    .count_out     (bit_cnt),
    .rollover_flag (byte_pulse)
  );

  bit_cnt_range: assert property (
    @(posedge clk) disable iff (rst) bit_cnt < ROLL
  );

  assign bus.rx_data       = data_q;
  assign bus.byte_received = byte_pulse;
  assign bus.stuff_err     = err_q;

endmodule

// File: tb/tb_rx_unstuff_shift.sv
// Directed bench for rx_unstuff_shift.
// Inputs change on negedge; outputs sampled one negedge later.
module tb_rx_unstuff_shift;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rx_unstuff_shift_if #(.DATA_BITS(8)) bus();

  rx_unstuff_shift #(
    .DATA_BITS (8),
    .STUFF_RUN (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic strobe(input logic d, input int gap,
                        output logic br, output logic se);
    bus.d_orig = d;
    bus.shift_enable = 1'b1;
    @(negedge clk);
    bus.shift_enable = 1'b0;
    br = bus.byte_received;
    se = bus.stuff_err;
    repeat (gap) @(negedge clk);
  endtask

  task automatic clear_eop;
    bus.eop = 1'b1;
    @(negedge clk);
    bus.eop = 1'b0;
  endtask

  task automatic test_reset;
    logic br, se;
    logic [7:0] v;
    for (int i = 0; i < 3; i++) strobe(1'b1, 0, br, se);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.rx_data !== 8'hFF) begin
      failures++;
      $display("FAIL reset_rx got=%h exp=ff", bus.rx_data);
    end
    checks++;
    if (bus.byte_received !== 1'b0 || bus.stuff_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses got=%b%b exp=00",
               bus.byte_received, bus.stuff_err);
    end
    v = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      strobe(v[i], 1, br, se);
      checks++;
      if (br !== (i == 7)) begin
        failures++;
        $display("FAIL reset_byte_br[%0d] got=%b exp=%b", i, br, i == 7);
      end
      if (i == 7) begin
        checks++;
        if (bus.rx_data !== 8'h5A) begin
          failures++;
          $display("FAIL reset_byte_rx got=%h exp=5a", bus.rx_data);
        end
      end
    end
  endtask

  task automatic test_plain;
    logic br, se;
    logic [7:0] v;
    clear_eop();
    v = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      strobe(v[i], (i == 7) ? 0 : 7, br, se);
      checks++;
      if (br !== (i == 7) || se !== 1'b0) begin
        failures++;
        $display("FAIL plain_br[%0d] got=%b/%b exp=%b/0", i, br, se, i == 7);
      end
    end
    checks++;
    if (bus.rx_data !== 8'hA5) begin
      failures++;
      $display("FAIL plain_rx got=%h exp=a5", bus.rx_data);
    end
    @(negedge clk);
    checks++;
    if (bus.byte_received !== 1'b0 || bus.rx_data !== 8'hA5) begin
      failures++;
      $display("FAIL plain_pulse_width got=%b rx=%h exp=0 rx=a5",
               bus.byte_received, bus.rx_data);
    end
  endtask

  task automatic test_stuffed;
    logic br, se;
    logic b [9];
    b = '{1, 1, 1, 1, 1, 1, 0, 0, 1};
    clear_eop();
    for (int i = 0; i < 9; i++) begin
      strobe(b[i], 1, br, se);
      checks++;
      if (br !== (i == 8) || se !== 1'b0) begin
        failures++;
        $display("FAIL stuffed_br[%0d] got=%b/%b exp=%b/0", i, br, se, i == 8);
      end
      if (i == 8) begin
        checks++;
        if (bus.rx_data !== 8'hBF) begin
          failures++;
          $display("FAIL stuffed_rx got=%h exp=bf", bus.rx_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic br, se;
    logic b [18];
    b = '{1, 1, 1, 1, 1, 1, 0, 1, 1,
          1, 1, 1, 1, 0, 0, 0, 0, 0};
    clear_eop();
    for (int i = 0; i < 18; i++) begin
      strobe(b[i], 0, br, se);
      checks++;
      if (br !== (i == 8 || i == 17) || se !== 1'b0) begin
        failures++;
        $display("FAIL cross_br[%0d] got=%b/%b exp=%b/0",
                 i, br, se, i == 8 || i == 17);
      end
      if (i == 8) begin
        checks++;
        if (bus.rx_data !== 8'hFF) begin
          failures++;
          $display("FAIL cross_rx0 got=%h exp=ff", bus.rx_data);
        end
      end
      if (i == 17) begin
        checks++;
        if (bus.rx_data !== 8'h0F) begin
          failures++;
          $display("FAIL cross_rx1 got=%h exp=0f", bus.rx_data);
        end
      end
    end
  endtask

  task automatic test_stuff_err;
    logic br, se;
    clear_eop();
    for (int i = 0; i < 7; i++) begin
      strobe(1'b1, 0, br, se);
      checks++;
      if (se !== (i == 6) || br !== 1'b0) begin
        failures++;
        $display("FAIL stuff_err[%0d] got=%b/%b exp=%b/0", i, se, br, i == 6);
      end
    end
    checks++;
    if (bus.rx_data !== 8'hFC) begin
      failures++;
      $display("FAIL stuff_err_rx got=%h exp=fc", bus.rx_data);
    end
    @(negedge clk);
    checks++;
    if (bus.stuff_err !== 1'b0) begin
      failures++;
      $display("FAIL stuff_err_width got=%b exp=0", bus.stuff_err);
    end
  endtask

  task automatic test_eop;
    logic br, se;
    logic [7:0] v;
    clear_eop();
    strobe(1'b1, 0, br, se);
    strobe(1'b0, 0, br, se);
    strobe(1'b1, 0, br, se);
    bus.eop = 1'b1;
    bus.d_orig = 1'b1;
    bus.shift_enable = 1'b1;
    @(negedge clk);
    bus.eop = 1'b0;
    bus.shift_enable = 1'b0;
    checks++;
    if (bus.byte_received !== 1'b0 || bus.rx_data !== 8'hBF) begin
      failures++;
      $display("FAIL eop_hold got=%b rx=%h exp=0 rx=bf",
               bus.byte_received, bus.rx_data);
    end
    v = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      strobe(v[i], 0, br, se);
      checks++;
      if (br !== (i == 7) || se !== 1'b0) begin
        failures++;
        $display("FAIL eop_next_br[%0d] got=%b/%b exp=%b/0", i, br, se, i == 7);
      end
    end
    checks++;
    if (bus.rx_data !== 8'h3C) begin
      failures++;
      $display("FAIL eop_next_rx got=%h exp=3c", bus.rx_data);
    end
    @(negedge clk);
    checks++;
    if (bus.byte_received !== 1'b0) begin
      failures++;
      $display("FAIL eop_next_width got=%b exp=0", bus.byte_received);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.d_orig = 1'b0;
    bus.shift_enable = 1'b0;
    bus.eop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_plain();
    test_stuffed();
    test_back_to_back();
    test_stuff_err();
    test_eop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
